uart_byte_tx: RTL

//  Serialises the 8-bit result of the mux stage (LEDR[7:0] value) onto UART_TXD as 8N1 (8E1 optional).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_byte_tx_if.sv | 24 ++
 rtl/uart_baud_tick.sv | 45 ++++
 rtl/uart_byte_tx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART byte transmitter.
//   DATA_BITS    : payload width of one frame (8)
//   tx_state_t   : transmitter FSM states
//   clks_per_bit : clock cycles per line bit, CLK_HZ/BAUD truncated
// Configuration macro: UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// ----------------------------------------------------------------------------
// uart_byte_tx_if
// Valid/ready byte handshake between a byte producer and uart_byte_tx.
//   tx_data  : byte to send, sampled on accept
//   tx_valid : request from the producer
//   tx_ready : transmitter idle and able to accept
//   tx_busy  : frame in progress
//   tx_done  : one-cycle pulse in the last cycle of the stop bit
// Modports: master (producer side), slave (transmitter side).
// ----------------------------------------------------------------------------
interface uart_byte_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (output tx_data, output tx_valid,
                    input  tx_ready, input tx_busy, input tx_done);
    modport slave  (input  tx_data, input tx_valid,
                    output tx_ready, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; held at 0 while
// clear is high so every bit period starts from a known phase.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force counter to 0 on the next edge
//   tick       : counter at terminal count CLKS_PER_BIT-1 (last cycle of a bit)
//   pre_tick   : counter at CLKS_PER_BIT-2 (one cycle before tick)
// CLKS_PER_BIT must be >= 2.
// ----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; next-state logic lives in always_comb with blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == LAST);
    assign pre_tick = (cnt_q == PRE);
endmodule

// File: rtl/uart_byte_tx.sv
// ----------------------------------------------------------------------------
// uart_byte_tx
// Serialises one byte per handshake onto uart_txd as 8N1, or 8E1 when the
// UART_TX_PARITY_EN macro is defined.
//   clk, reset : clock, asynchronous active-high reset
//   tx_if      : slave side of the valid/ready byte handshake
//   uart_txd   : serial line, idle high
// Every output comes straight from a flop; the _d values are computed from
// the next state so the line changes in the cycle after the decision edge.
// ----------------------------------------------------------------------------
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic           clk,
    input  logic           reset,
    uart_byte_tx_if.slave  tx_if,
    output logic           uart_txd
);
    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic tick;
    logic pre_tick;

    // Counter is held clear in IDLE so the start bit begins at phase 0; every
    // later state change happens on tick, where the counter wraps to 0 anyway.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q == IDLE),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_if.tx_valid && ready_q) begin
                    state_d   = START;
                    shift_d   = tx_if.tx_data;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^tx_if.tx_data;
`endif
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                // Registered, so raise it one cycle early to land in the last stop cycle.
                done_d = pre_tick;
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, keeping uart_txd a flop.
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign uart_txd       = txd_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_if.tx_busy  = busy_q;
    assign tx_if.tx_done  = done_q;
endmodule
